// File: rtl/txd_pkg.sv
// Shared types and constants for the txd UART transmitter.
package txd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int   DATA_BITS   = 8;
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/txd_if.sv
// Byte-write and status bundle between a producer and the txd transmitter.
interface txd_if;
    import txd_pkg::*;

    logic [DATA_BITS-1:0] d;
    logic                 send;
    logic                 txd;
    logic                 busy;
    logic                 empty;
    logic                 full;
    logic                 err;

    // Producer side: writes bytes, watches line and status.
    modport master (
        output d, send,
        input  txd, busy, empty, full, err
    );

    // Transmitter side.
    modport slave (
        input  d, send,
        output txd, busy, empty, full, err
    );

endinterface

// File: rtl/txd_fifo.sv
// Synchronous DEPTH x 8 FIFO with registered occupancy count.
module txd_fifo
    import txd_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] wdata,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 empty,
    output logic                 full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic                 wr_en;
    logic                 rd_en;

    // Full/empty come from the registered count, so a pop never frees room
    // for a push on the same edge.
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];

    // Storage write port.
    // NOTE: the data array has no reset; only pointers and count define what
    // is valid, so clearing the storage would buy nothing.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/txd.sv
// UART transmitter: queues bytes and sends start, 8 data bits LSB-first and
// STOP_BITS stop bits, one bit per baud-clock edge.
module txd
    import txd_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int STOP_BITS = 2
) (
    input  logic  clk_9600Hz,
    input  logic  rst_n,
    txd_if.slave  bus
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [1:0] LAST_STOP = 2'(STOP_BITS - 1);

    state_t               state;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] head;
    logic [2:0]           bit_cnt;
    logic [1:0]           stop_cnt;
    logic                 line;
    logic                 busy_q;
    logic                 err_q;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 last_stop;
    logic                 pop;

    txd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_9600Hz),
        .rst_n (rst_n),
        .push  (bus.send),
        .pop   (pop),
        .wdata (bus.d),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A new frame starts from idle, or straight after the final stop bit so
    // queued bytes go out with no idle gap.
    assign last_stop = (state == STOP) && (stop_cnt == LAST_STOP);
    assign pop       = !fifo_empty && ((state == IDLE) || last_stop);

    assign bus.txd   = line;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
    assign bus.empty = fifo_empty;
    assign bus.full  = fifo_full;

    // Frame sequencer with registered line and busy outputs.
    always_ff @(posedge clk_9600Hz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            line     <= LINE_IDLE;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift  <= head;
                        state  <= START;
                        line   <= START_LEVEL;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    line    <= shift[0];
                    shift   <= shift >> 1;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        line     <= LINE_IDLE;
                        stop_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        line    <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        if (pop) begin
                            shift <= head;
                            line  <= START_LEVEL;
                            state <= START;
                        end else begin
                            line   <= LINE_IDLE;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-cycle flag for a write refused because the queue was full.
    always_ff @(posedge clk_9600Hz or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= bus.send && fifo_full;
        end
    end

endmodule

// File: tb/tb_txd.sv
// Self-checking bench for txd: frame-level model plus directed scenarios.
module tb_txd;

    localparam int DEPTH     = 4;
    localparam int STOP_BITS = 2;

    logic clk_9600Hz = 1'b0;
    logic rst_n      = 1'b0;

    txd_if bus();

    txd #(.DEPTH(DEPTH), .STOP_BITS(STOP_BITS)) dut (
        .clk_9600Hz (clk_9600Hz),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 clk_9600Hz = ~clk_9600Hz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    // Bytes waiting in the queue, and line bits still to be shown for the
    // frame currently on the wire.
    logic [7:0] byte_q [$];
    logic       bit_q  [$];
    logic       m_txd  = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_err  = 1'b0;

    initial begin
        forever begin
            @(posedge clk_9600Hz or negedge rst_n);
            if (!rst_n) begin
                byte_q.delete();
                bit_q.delete();
                m_txd  = 1'b1;
                m_busy = 1'b0;
                m_err  = 1'b0;
            end else begin
                automatic bit         was_full  = (byte_q.size() == DEPTH);
                automatic bit         was_empty = (byte_q.size() == 0);
                automatic logic [7:0] b;
                m_err = bus.send && was_full;
                if (bit_q.size() == 0 && !was_empty) begin
                    b = byte_q.pop_front();
                    bit_q.push_back(1'b0);
                    for (int i = 0; i < 8; i++) bit_q.push_back(b[i]);
                    for (int i = 0; i < STOP_BITS; i++) bit_q.push_back(1'b1);
                end
                if (bit_q.size() != 0) begin
                    m_txd  = bit_q.pop_front();
                    m_busy = 1'b1;
                end else begin
                    m_txd  = 1'b1;
                    m_busy = 1'b0;
                end
                if (bus.send && !was_full) byte_q.push_back(bus.d);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_9600Hz);
            check("cmp_txd",   32'(bus.txd),   32'(m_txd));
            check("cmp_busy",  32'(bus.busy),  32'(m_busy));
            check("cmp_err",   32'(bus.err),   32'(m_err));
            check("cmp_empty", 32'(bus.empty), 32'(byte_q.size() == 0));
            check("cmp_full",  32'(bus.full),  32'(byte_q.size() == DEPTH));
        end
    end

    // ---------------- Line decoder (stands in for the team receiver) -------
    logic [7:0] rx_q [$];
    logic       rx_err    = 1'b0;
    logic       rx_active = 1'b0;
    int         rx_cnt    = 0;
    logic [7:0] rx_sh     = '0;

    initial begin
        forever begin
            @(negedge clk_9600Hz or negedge rst_n);
            if (!rst_n) begin
                rx_active = 1'b0;
                rx_cnt    = 0;
                rx_err    = 1'b0;
            end else if (!rx_active) begin
                if (bus.txd == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else if (rx_cnt < 8) begin
                rx_sh[rx_cnt] = bus.txd;
                rx_cnt++;
            end else begin
                if (bus.txd == 1'b1) rx_q.push_back(rx_sh);
                else                 rx_err = 1'b1;
                rx_active = 1'b0;
            end
        end
    end

    // ---------------- Stimulus helpers ----------------
    logic [0:63] cap;
    int          busy_cnt;

    task automatic tick();
        @(posedge clk_9600Hz);
        #1;
    endtask

    // Record n line bits: the current one, then one per following edge.
    task automatic capture(input int n);
        busy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            cap[i] = bus.txd;
            if (bus.busy) busy_cnt++;
        end
    endtask

    logic [0:10] exp_a5   = 11'b0_10100101_11;
    logic [0:21] exp_b2b  = 22'b0_00000000_11_0_11111111_11;
    logic [7:0]  exp_ovf [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

    initial begin
        // Reset held with a write strobe active: nothing may be queued.
        bus.d    = 8'h55;
        bus.send = 1'b1;
        rst_n    = 1'b0;
        repeat (3) tick();
        check("rst_txd",   32'(bus.txd),   32'd1);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full",  32'(bus.full),  32'd0);
        check("rst_err",   32'(bus.err),   32'd0);
        bus.send = 1'b0;
        rst_n    = 1'b1;
        repeat (3) tick();
        check("post_rst_empty", 32'(bus.empty), 32'd1);
        check("post_rst_txd",   32'(bus.txd),   32'd1);

        // Single byte 0xA5.
        rx_q.delete();
        bus.d    = 8'hA5;
        bus.send = 1'b1;
        tick();
        bus.send = 1'b0;
        check("a5_empty_after_push", 32'(bus.empty), 32'd0);
        check("a5_txd_before_start", 32'(bus.txd),   32'd1);
        tick();
        check("a5_empty_after_pop",  32'(bus.empty), 32'd1);
        capture(11);
        check("a5_frame",     32'(cap[0:10]), 32'(exp_a5));
        check("a5_busy_cnt",  32'(busy_cnt),  32'd11);
        tick();
        check("a5_idle_txd",  32'(bus.txd),   32'd1);
        check("a5_idle_busy", 32'(bus.busy),  32'd0);
        check("a5_rx_cnt",    32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) check("a5_rx_byte", 32'(rx_q[0]), 32'hA5);

        // Back-to-back 0x00 then 0xFF.
        rx_q.delete();
        repeat (2) tick();
        bus.d    = 8'h00;
        bus.send = 1'b1;
        tick();
        bus.d    = 8'hFF;
        tick();
        bus.send = 1'b0;
        capture(22);
        check("b2b_frames",   32'(cap[0:21]), 32'(exp_b2b));
        check("b2b_busy_cnt", 32'(busy_cnt),  32'd22);
        tick();
        check("b2b_idle_busy", 32'(bus.busy), 32'd0);
        check("b2b_rx_cnt",    32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", 32'(rx_q[0]), 32'h00);
            check("b2b_rx1", 32'(rx_q[1]), 32'hFF);
        end

        // Overflow: six writes on consecutive edges from idle.
        rx_q.delete();
        repeat (2) tick();
        for (int i = 1; i <= 6; i++) begin
            bus.d    = 8'(i);
            bus.send = 1'b1;
            tick();
            if (i == 4) check("ovf_not_full_4", 32'(bus.full), 32'd0);
            if (i == 5) begin
                check("ovf_full_5", 32'(bus.full), 32'd1);
                check("ovf_err_5",  32'(bus.err),  32'd0);
            end
            if (i == 6) check("ovf_err_6", 32'(bus.err), 32'd1);
        end
        bus.send = 1'b0;
        tick();
        check("ovf_err_pulse_end", 32'(bus.err), 32'd0);
        repeat (60) tick();
        check("ovf_rx_cnt", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < rx_q.size() && i < 5; i++)
            check("ovf_rx_byte", 32'(rx_q[i]), 32'(exp_ovf[i]));
        check("ovf_idle_empty", 32'(bus.empty), 32'd1);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        rx_q.delete();
        bus.d    = 8'h3C;
        bus.send = 1'b1;
        tick();
        bus.d    = 8'h11;
        tick();
        bus.d    = 8'h22;
        tick();
        bus.send = 1'b0;
        repeat (3) tick();
        check("mid_bit3_txd",  32'(bus.txd),   32'd1);
        check("mid_busy",      32'(bus.busy),  32'd1);
        check("mid_queued",    32'(bus.empty), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid_async_txd",   32'(bus.txd),   32'd1);
        check("mid_async_busy",  32'(bus.busy),  32'd0);
        check("mid_async_empty", 32'(bus.empty), 32'd1);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("mid_after_txd",  32'(bus.txd),  32'd1);
            check("mid_after_busy", 32'(bus.busy), 32'd0);
        end
        check("mid_rx_none", 32'(rx_q.size()), 32'd0);

        // Loopback through the line decoder.
        rx_q.delete();
        bus.d    = 8'h3C;
        bus.send = 1'b1;
        tick();
        bus.d    = 8'hC3;
        tick();
        bus.send = 1'b0;
        repeat (30) tick();
        check("loop_rx_cnt", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) begin
            check("loop_rx0", 32'(rx_q[0]), 32'h3C);
            check("loop_rx1", 32'(rx_q[1]), 32'hC3);
        end
        check("loop_rx_err", 32'(rx_err), 32'd0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/txd.md
# txd

UART transmitter for the 9600 Hz baud-clock domain: the sending counterpart of the serial receiver on the same line. Bytes written through a strobe interface are queued in a small FIFO. Each byte is serialized as one start bit (0), 8 data bits LSB-first and STOP_BITS stop bits (1), one bit per clock. The default framing leaves the idle cycle the team's receiver needs between frames.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- STOP_BITS, 2: stop-bit cycles per frame, 1..4. Keep it at 2 or more when driving the team receiver, so it sees line-high on the cycle after its stop sample.

- clk_9600Hz  in  1  baud clock; one bit time per rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d  in  8  byte to queue.
- send  in  1  write strobe; sampled every edge.
- txd  out  1  serial line; idle high.
- busy  out  1  frame in progress (start, data or stop bit on txd).
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds DEPTH bytes.
- err  out  1  one-cycle pulse: send was refused because the FIFO was full.

## Operation
- Reset values: txd=1, busy=0, empty=1, full=0, err=0. FIFO pointers and count are 0; FSM is in IDLE.
- Push: on an edge with send=1 and full=0, d is written to the FIFO.
- Push when full=1: d is dropped and err=1 for the next cycle. A pop in the same cycle does not rescue the push, because full is decoded from the registered count.
- Pop: in IDLE with empty=0, the head byte is loaded into an 8-bit shift register and the FSM enters START. A push and a pop on the same edge leave the count unchanged.
- FSM states:
  - IDLE: txd=1.
  - START: txd=0 for 1 cycle, then DATA.
  - DATA: txd=shift[0]; shift right each cycle; 3-bit bit_cnt runs 0..7; after bit 7, go to STOP.
  - STOP: txd=1 for STOP_BITS cycles. On the last stop cycle, if empty=0, pop immediately and go to START. Otherwise go to IDLE.
- No bypass: a byte pushed into an empty FIFO is popped on the following edge.
- busy=1 in START, DATA and STOP.
- txd, busy and err are registered outputs; no combinational path from inputs to outputs.
- FIFO count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- Push at edge N: empty=0 after N. The start bit is on txd after edge N+1, and busy rises at N+1.
- Frame length is 9+STOP_BITS cycles (11 by default).
- Back-to-back frames: the next start bit follows the last stop bit with zero idle cycles.
- Reset mid-frame: txd goes to 1 and busy to 0 immediately (asynchronously). The FIFO is flushed and the partial frame is abandoned. After rst_n deasserts, nothing is sent until a new push.

## Structure
- Package txd_pkg holds:
  - state enum (IDLE, START, DATA, STOP);
  - DATA_BITS=8;
  - LINE_IDLE=1'b1 and START_LEVEL=1'b0.
- Sub-module txd_fifo: synchronous DEPTH×8 FIFO with push/pop, registered count, full and empty, on the same clock and reset.
- The top level holds the FSM, shift register, bit/stop counters and the err register.

## Test plan
- Reset: hold rst_n=0 with send=1 and d=0x55 -> txd=1, busy=0, empty=1, full=0, err=0; nothing is queued.
- Single byte: push 0xA5 at edge N -> from edge N+1, txd reads 0,1,0,1,0,0,1,0,1,1,1; busy=1 for exactly 11 cycles; empty=0 only between edges N and N+1.
- Back-to-back: push 0x00 then 0xFF on consecutive edges -> 22 contiguous cycles on txd: 0, eight 0s, 1,1, then 0, eight 1s, 1,1. busy never drops in between.
- Overflow, DEPTH=4: push 0x01..0x06 on 6 consecutive edges starting while idle -> full=1 after the 5th push; the 6th push is refused with err=1 for one cycle; 0x01..0x05 are transmitted in order and 0x06 is never sent.
- Reset mid-frame: pulse rst_n low during data bit 3 of 0x3C with two bytes still queued -> txd=1 immediately; after release txd stays 1 and busy=0 indefinitely.
- Loopback: txd tied to the team receiver's rxd, push 0x3C then 0xC3 -> the receiver outputs c=0x3C then c=0xC3, each with a recieve pulse; the receiver's err stays 0 throughout.
